// File: rtl/wb_gpio_pkg.sv
// Shared definitions for the Wishbone GPIO/interrupt controller:
// register offsets, priming FSM states and small helper functions.
package wb_gpio_pkg;

  localparam logic [7:0] OFF_OUT  = 8'h00;
  localparam logic [7:0] OFF_OEB  = 8'h08;
  localparam logic [7:0] OFF_IN   = 8'h10;
  localparam logic [7:0] OFF_RISE = 8'h18;
  localparam logic [7:0] OFF_FALL = 8'h20;
  localparam logic [7:0] OFF_MASK = 8'h28;
  localparam logic [7:0] OFF_STAT = 8'h30;

  // Wide enough to hold SYNC_STAGES+1 for the largest legal SYNC_STAGES.
  localparam int PRIME_W = 3;

  typedef enum logic [0:0] {
    PRIME = 1'b0,
    RUN   = 1'b1
  } prime_state_e;

  function automatic int irq_line(input int ch, input int n_irq);
    return ch % n_irq;
  endfunction

  // Byte-enable merge of a 32-bit bus word into the LO or HI half of a 64-bit register.
  function automatic logic [63:0] sel_merge(input logic [63:0] old_v, input logic hi,
                                            input logic [31:0] data, input logic [3:0] sel);
    logic [63:0] res;
    int          lsb;
    res = old_v;
    for (int b = 32'sd0; b < 32'sd4; b++) begin
      lsb = (hi ? 32'sd32 : 32'sd0) + 32'sd8 * b;
      res[lsb +: 8] = sel[b] ? data[8*b +: 8] : res[lsb +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/gpio_sync_edge.sv
// Pad input synchroniser, per-channel history and qualified edge events,
// with a post-reset priming window that blocks edges from reset values.
module gpio_sync_edge
  import wb_gpio_pkg::*;
#(
  parameter int WIDTH       = 38,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  input  logic [WIDTH-1:0] rise_en,
  input  logic [WIDTH-1:0] fall_en,
  output logic [WIDTH-1:0] sync_q,
  output logic [WIDTH-1:0] edge_ev
);

  localparam logic [PRIME_W-1:0] PRIME_LOAD = PRIME_W'(SYNC_STAGES + 1);

  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_r;
  logic [WIDTH-1:0]                  prev_r;
  prime_state_e                      state_r, state_s;
  logic [PRIME_W-1:0]                cnt_r, cnt_s;
  logic                              run_s;

  // Synchroniser chain and history flops; history keeps tracking while priming.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_r <= {(SYNC_STAGES*WIDTH){1'b0}};
      prev_r <= {WIDTH{1'b0}};
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], d};
      prev_r <= sync_r[SYNC_STAGES-1];
    end
  end

  // Priming state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= PRIME;
      cnt_r   <= PRIME_LOAD;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
    end
  end

  // Priming next-state: count down, enter RUN as the counter reaches zero.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    case (state_r)
      PRIME: begin
        cnt_s = cnt_r - PRIME_W'(1);
        if (cnt_r == PRIME_W'(1)) begin
          state_s = RUN;
        end else begin
          state_s = PRIME;
        end
      end
      RUN: begin
        state_s = RUN;
        cnt_s   = {PRIME_W{1'b0}};
      end
      default: begin
        state_s = PRIME;
        cnt_s   = PRIME_LOAD;
      end
    endcase
  end

  // Edge qualification against the enables, gated off until priming completes.
  always_comb begin
    run_s  = (state_r == RUN);
    sync_q = sync_r[SYNC_STAGES-1];
    if (run_s) begin
      edge_ev = (sync_q & ~prev_r & rise_en) | (~sync_q & prev_r & fall_en);
    end else begin
      edge_ev = {WIDTH{1'b0}};
    end
  end

endmodule

// File: rtl/wb_gpio_irq.sv
// Wishbone-slave GPIO bank: register decode, pad drive, sticky edge STATUS
// and masked interrupt folding onto user_irq.
module wb_gpio_irq
  import wb_gpio_pkg::*;
#(
  parameter int          N_IO        = 38,
  parameter int          N_IRQ       = 3,
  parameter logic [31:0] BASE_ADDR   = 32'h3000_0000,
  parameter int          SYNC_STAGES = 2
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic             wbs_cyc_i,
  input  logic             wbs_stb_i,
  input  logic             wbs_we_i,
  input  logic [3:0]       wbs_sel_i,
  input  logic [31:0]      wbs_adr_i,
  input  logic [31:0]      wbs_dat_i,
  output logic             wbs_ack_o,
  output logic [31:0]      wbs_dat_o,
  input  logic [N_IO-1:0]  io_in,
  output logic [N_IO-1:0]  io_out,
  output logic [N_IO-1:0]  io_oeb,
  output logic [N_IRQ-1:0] user_irq
);

  localparam logic [63:0] VALID_MASK = (N_IO >= 64) ? {64{1'b1}} : ((64'd1 << N_IO) - 64'd1);

  logic             hit_s, acc_s, wr_s, hi_s;
  logic [7:0]       off_s;
  logic [63:0]      rd64_s, wval_s, clr_s, in64_s, ev64_s;
  logic [31:0]      rdata_s;
  logic [N_IO-1:0]  sync_s, ev_s, pend_s;
  logic [N_IRQ-1:0] irq_s;
  logic             unused_s;

  logic             ack_r;
  logic [31:0]      dat_r;
  logic [63:0]      out_r, oeb_r, rise_r, fall_r, mask_r, stat_r;
  logic [N_IRQ-1:0] irq_r;

  gpio_sync_edge #(
    .WIDTH      (N_IO),
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync_edge (
    .clk    (wb_clk_i),
    .rst    (wb_rst_i),
    .d      (io_in),
    .rise_en(rise_r[N_IO-1:0]),
    .fall_en(fall_r[N_IO-1:0]),
    .sync_q (sync_s),
    .edge_ev(ev_s)
  );

  // Byte-lane address bits carry no meaning in a 32-bit register window.
  assign unused_s = ^wbs_adr_i[1:0];

  // Window decode; the cycle after an ack never starts a new access.
  always_comb begin
    hit_s  = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:8] == BASE_ADDR[31:8]);
    acc_s  = hit_s & ~ack_r;
    wr_s   = acc_s & wbs_we_i;
    off_s  = {wbs_adr_i[7:3], 3'b000};
    hi_s   = wbs_adr_i[2];
    in64_s = 64'(sync_s);
    ev64_s = 64'(ev_s);
  end

  // Read mux; the selected register also serves as the old value for write merging.
  always_comb begin
    case (off_s)
      OFF_OUT:  rd64_s = out_r;
      OFF_OEB:  rd64_s = oeb_r;
      OFF_IN:   rd64_s = in64_s;
      OFF_RISE: rd64_s = rise_r;
      OFF_FALL: rd64_s = fall_r;
      OFF_MASK: rd64_s = mask_r;
      OFF_STAT: rd64_s = stat_r;
      default:  rd64_s = 64'd0;
    endcase
    rdata_s = hi_s ? rd64_s[63:32] : rd64_s[31:0];
    wval_s  = sel_merge(rd64_s, hi_s, wbs_dat_i, wbs_sel_i) & VALID_MASK;
    if (wr_s && (off_s == OFF_STAT)) begin
      clr_s = sel_merge(64'd0, hi_s, wbs_dat_i, wbs_sel_i);
    end else begin
      clr_s = 64'd0;
    end
  end

  // Bus handshake: single-cycle ack, read data only alongside a read ack.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      ack_r <= 1'b0;
      dat_r <= 32'd0;
    end else begin
      ack_r <= acc_s;
      if (acc_s && !wbs_we_i) begin
        dat_r <= rdata_s;
      end else begin
        dat_r <= 32'd0;
      end
    end
  end

  // Software-writable configuration registers; reset leaves every pad as an input.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      out_r  <= 64'd0;
      oeb_r  <= VALID_MASK;
      rise_r <= 64'd0;
      fall_r <= 64'd0;
      mask_r <= 64'd0;
    end else if (wr_s) begin
      case (off_s)
        OFF_OUT:  out_r  <= wval_s;
        OFF_OEB:  oeb_r  <= wval_s;
        OFF_RISE: rise_r <= wval_s;
        OFF_FALL: fall_r <= wval_s;
        OFF_MASK: mask_r <= wval_s;
        default:  out_r  <= out_r;
      endcase
    end else begin
      out_r <= out_r;
    end
  end

  // Sticky status (a same-cycle event beats a write-one-to-clear) and registered irq.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      stat_r <= 64'd0;
      irq_r  <= {N_IRQ{1'b0}};
    end else begin
      stat_r <= ((stat_r & ~clr_s) | ev64_s) & VALID_MASK;
      irq_r  <= irq_s;
    end
  end

  // Channel i feeds irq line i mod N_IRQ.
  always_comb begin
    pend_s = stat_r[N_IO-1:0] & mask_r[N_IO-1:0];
    irq_s  = {N_IRQ{1'b0}};
    for (int k = 32'sd0; k < N_IRQ; k++) begin
      for (int i = 32'sd0; i < N_IO; i++) begin
        irq_s[k] = irq_s[k] | (pend_s[i] & (irq_line(i, N_IRQ) == k));
      end
    end
  end

  assign wbs_ack_o = ack_r;
  assign wbs_dat_o = dat_r;
  assign io_out    = out_r[N_IO-1:0];
  assign io_oeb    = oeb_r[N_IO-1:0];
  assign user_irq  = irq_r;

endmodule
